// File: rtl/decode_queue_if.sv
// Fetch-side handshake and dispatch-side lane bundle of the decode queue.
// slave is the queue's own view; master is the fetch/dispatch (or bench) view.
interface decode_queue_if #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ISSUE_WIDTH = 2
);
  localparam int unsigned DW = $clog2(ISSUE_WIDTH + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                          flush_in;
  logic                          fetch_valid_in;
  logic                          fetch_ready_out;
  logic [31:0]                   instruction_in;
  logic [31:0]                   pc_in;
  logic [DW-1:0]                 deq_count_in;
  logic [ISSUE_WIDTH-1:0]        lane_valid_out;
  logic [ISSUE_WIDTH-1:0][31:0]  iType_out;
  logic [ISSUE_WIDTH-1:0][31:0]  aluFunc_out;
  logic [ISSUE_WIDTH-1:0][31:0]  brFunc_out;
  logic [ISSUE_WIDTH-1:0][31:0]  imm_out;
  logic [ISSUE_WIDTH-1:0][31:0]  pc_out;
  logic [ISSUE_WIDTH-1:0][4:0]   rs1_out;
  logic [ISSUE_WIDTH-1:0][4:0]   rs2_out;
  logic [ISSUE_WIDTH-1:0][4:0]   rd_out;
  logic [ISSUE_WIDTH-1:0]        illegal_out;
  logic [CW-1:0]                 count_out;

  modport master (
    output flush_in, fetch_valid_in, instruction_in, pc_in, deq_count_in,
    input  fetch_ready_out, lane_valid_out, iType_out, aluFunc_out, brFunc_out,
           imm_out, pc_out, rs1_out, rs2_out, rd_out, illegal_out, count_out
  );

  modport slave (
    input  flush_in, fetch_valid_in, instruction_in, pc_in, deq_count_in,
    output fetch_ready_out, lane_valid_out, iType_out, aluFunc_out, brFunc_out,
           imm_out, pc_out, rs1_out, rs2_out, rd_out, illegal_out, count_out
  );
endinterface

// File: rtl/decode_queue.sv
// RV32I decode stage: decodes at enqueue into a fixed record, buffers records in
// an in-order circular queue and presents the oldest ISSUE_WIDTH to dispatch.
module decode_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ISSUE_WIDTH = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  decode_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    IT_NONE, IT_OP, IT_OPIMM, IT_LOAD, IT_STORE,
    IT_BRANCH, IT_LUI, IT_AUIPC, IT_JAL, IT_JALR
  } i_type_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_func_e;

  typedef enum logic [2:0] {
    BR_EQ, BR_NEQ, BR_LT, BR_GE, BR_LTU, BR_GEU
  } br_func_e;

  typedef struct packed {
    i_type_e     itype;
    alu_func_e   alu;
    br_func_e    br;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
  } rec_t;

  // SYSTEM has no iType encoding, so 1110011 falls into the illegal default.
  function automatic rec_t decode(input logic [31:0] inst, input logic [31:0] pc);
    rec_t        r;
    logic        bad;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    r   = '0;
    bad = 1'b0;
    case (inst[6:0])
      7'b0110011: begin
        r.itype = IT_OP;
        r.rs1   = inst[19:15];
        r.rs2   = inst[24:20];
        r.rd    = inst[11:7];
        case ({inst[31:25], inst[14:12]})
          {7'h00, 3'd0}: r.alu = ALU_ADD;
          {7'h20, 3'd0}: r.alu = ALU_SUB;
          {7'h00, 3'd1}: r.alu = ALU_SLL;
          {7'h00, 3'd2}: r.alu = ALU_SLT;
          {7'h00, 3'd3}: r.alu = ALU_SLTU;
          {7'h00, 3'd4}: r.alu = ALU_XOR;
          {7'h00, 3'd5}: r.alu = ALU_SRL;
          {7'h20, 3'd5}: r.alu = ALU_SRA;
          {7'h00, 3'd6}: r.alu = ALU_OR;
          {7'h00, 3'd7}: r.alu = ALU_AND;
          default:       bad   = 1'b1;
        endcase
      end
      7'b0010011: begin
        r.itype = IT_OPIMM;
        r.rs1   = inst[19:15];
        r.rd    = inst[11:7];
        r.imm   = imm_i;
        case (inst[14:12])
          3'd0: r.alu = ALU_ADD;
          3'd1: begin
            if (inst[31:25] == 7'h00) r.alu = ALU_SLL;
            else                      bad   = 1'b1;
          end
          3'd2: r.alu = ALU_SLT;
          3'd3: r.alu = ALU_SLTU;
          3'd4: r.alu = ALU_XOR;
          3'd5: begin
            if (inst[31:25] == 7'h00)      r.alu = ALU_SRL;
            else if (inst[31:25] == 7'h20) r.alu = ALU_SRA;
            else                           bad   = 1'b1;
          end
          3'd6: r.alu = ALU_OR;
          default: r.alu = ALU_AND;
        endcase
      end
      7'b0000011, 7'b1100111: begin
        r.itype = (inst[6:0] == 7'b0000011) ? IT_LOAD : IT_JALR;
        r.rs1   = inst[19:15];
        r.rd    = inst[11:7];
        r.imm   = imm_i;
      end
      7'b0100011: begin
        r.itype = IT_STORE;
        r.rs1   = inst[19:15];
        r.rs2   = inst[24:20];
        r.imm   = imm_s;
      end
      7'b1100011: begin
        r.itype = IT_BRANCH;
        r.rs1   = inst[19:15];
        r.rs2   = inst[24:20];
        r.imm   = imm_b;
        case (inst[14:12])
          3'd0:    r.br = BR_EQ;
          3'd1:    r.br = BR_NEQ;
          3'd4:    r.br = BR_LT;
          3'd5:    r.br = BR_GE;
          3'd6:    r.br = BR_LTU;
          3'd7:    r.br = BR_GEU;
          default: bad  = 1'b1;
        endcase
      end
      7'b0110111, 7'b0010111: begin
        r.itype = (inst[6:0] == 7'b0110111) ? IT_LUI : IT_AUIPC;
        r.rd    = inst[11:7];
        r.imm   = imm_u;
      end
      7'b1101111: begin
        r.itype = IT_JAL;
        r.rd    = inst[11:7];
        r.imm   = imm_j;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      r         = '0;
      r.illegal = 1'b1;
    end
    r.pc = pc;
    return r;
  endfunction

  rec_t          mem [DEPTH];
  rec_t          enq_rec;
  rec_t          lane_rec;
  logic [PW-1:0] head, tail, lane_idx;
  logic [CW-1:0] count, deq_req, deq_eff;
  logic          enq;

  always_comb begin
    bus.fetch_ready_out = (count < CW'(DEPTH));
    enq                 = bus.fetch_valid_in && (count < CW'(DEPTH));
    deq_req             = CW'(bus.deq_count_in);
    deq_eff             = (deq_req > count) ? count : deq_req;
    enq_rec             = decode(bus.instruction_in, bus.pc_in);
  end

  // Reset beats flush, flush beats any same-cycle enqueue/dequeue.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush_in) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      head  <= head + PW'(deq_eff);
      count <= count + CW'(enq) - deq_eff;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && !bus.flush_in && enq) mem[tail] <= enq_rec;
  end

  always_comb begin
    bus.lane_valid_out = '0;
    bus.iType_out      = '0;
    bus.aluFunc_out    = '0;
    bus.brFunc_out     = '0;
    bus.imm_out        = '0;
    bus.pc_out         = '0;
    bus.rs1_out        = '0;
    bus.rs2_out        = '0;
    bus.rd_out         = '0;
    bus.illegal_out    = '0;
    lane_idx           = '0;
    lane_rec           = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      lane_idx              = head + PW'(i);
      lane_rec              = mem[lane_idx];
      bus.lane_valid_out[i] = (count > CW'(i));
      bus.iType_out[i]      = 32'(lane_rec.itype);
      bus.aluFunc_out[i]    = 32'(lane_rec.alu);
      bus.brFunc_out[i]     = 32'(lane_rec.br);
      bus.imm_out[i]        = lane_rec.imm;
      bus.pc_out[i]         = lane_rec.pc;
      bus.rs1_out[i]        = lane_rec.rs1;
      bus.rs2_out[i]        = lane_rec.rs2;
      bus.rd_out[i]         = lane_rec.rd;
      bus.illegal_out[i]    = lane_rec.illegal;
    end
    bus.count_out = count;
  end
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: decode vector table, hand-written queue corner cases
// and a random run checked against a queue-based reference model.
module tb_decode_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned IW    = 2;

  localparam logic [31:0] IT_OP = 1, IT_OPIMM = 2, IT_LOAD = 3, IT_STORE = 4,
    IT_BRANCH = 5, IT_LUI = 6, IT_AUIPC = 7, IT_JAL = 8, IT_JALR = 9;
  localparam logic [31:0] ALU_ADD = 0, ALU_SUB = 1, ALU_XOR = 2, ALU_OR = 3,
    ALU_AND = 4, ALU_SLL = 5, ALU_SRL = 6, ALU_SRA = 7, ALU_SLT = 8, ALU_SLTU = 9;
  localparam logic [31:0] BR_EQ = 0, BR_NEQ = 1, BR_LT = 2, BR_GE = 3,
    BR_LTU = 4, BR_GEU = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(DEPTH), .ISSUE_WIDTH(IW)) bus ();
  decode_queue #(.DEPTH(DEPTH), .ISSUE_WIDTH(IW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [31:0] itype, alu, br, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    exp_t        e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t model[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] it, input logic [31:0] alu,
                              input logic [31:0] br, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic ill);
    exp_t e;
    e.itype = it; e.alu = alu; e.br = br; e.imm = imm; e.pc = 0;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.ill = ill;
    return e;
  endfunction

  // Reference decode from the ISA format rules, immediates by arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t        e;
    byte         fmt;
    logic        ok;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] alu_of_f3 [8];
    logic [31:0] br_of_f3 [8];
    alu_of_f3 = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    br_of_f3  = '{BR_EQ, BR_NEQ, 0, 0, BR_LT, BR_GE, BR_LTU, BR_GEU};
    e   = mk(0, 0, 0, 0, 0, 0, 0, 1'b0);
    f3  = w[14:12];
    f7  = w[31:25];
    ok  = 1'b1;
    fmt = "X";
    case (w[6:0])
      7'h33: begin
        fmt = "R"; e.itype = IT_OP;
        if (f7 == 0)                   e.alu = alu_of_f3[f3];
        else if (f7 == 7'h20 && f3 == 0) e.alu = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 5) e.alu = ALU_SRA;
        else ok = 1'b0;
      end
      7'h13: begin
        fmt = "I"; e.itype = IT_OPIMM;
        if (f3 == 1 && f7 != 0)              ok = 1'b0;
        else if (f3 == 5 && f7 == 7'h20)     e.alu = ALU_SRA;
        else if (f3 == 5 && f7 != 0)         ok = 1'b0;
        else                                 e.alu = alu_of_f3[f3];
      end
      7'h03: begin fmt = "I"; e.itype = IT_LOAD; end
      7'h67: begin fmt = "I"; e.itype = IT_JALR; end
      7'h23: begin fmt = "S"; e.itype = IT_STORE; end
      7'h63: begin
        fmt = "B"; e.itype = IT_BRANCH;
        if (f3 == 2 || f3 == 3) ok = 1'b0;
        else                    e.br = br_of_f3[f3];
      end
      7'h37: begin fmt = "U"; e.itype = IT_LUI; end
      7'h17: begin fmt = "U"; e.itype = IT_AUIPC; end
      7'h6F: begin fmt = "J"; e.itype = IT_JAL; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = mk(0, 0, 0, 0, 0, 0, 0, 1'b1);
      e.pc = pc;
      return e;
    end
    case (fmt)
      "R": begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; end
      "I": begin
        e.rs1 = w[19:15]; e.rd = w[11:7];
        e.imm = 32'(w[31:20]) - (w[31] ? 32'd4096 : 32'd0);
      end
      "S": begin
        e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.imm = 32'({w[31:25], w[11:7]}) - (w[31] ? 32'd4096 : 32'd0);
      end
      "B": begin
        e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.imm = 32'd2 * 32'({w[31], w[7], w[30:25], w[11:8]}) - (w[31] ? 32'd8192 : 32'd0);
      end
      "U": begin e.rd = w[11:7]; e.imm = 32'(w[31:12]) * 32'd4096; end
      default: begin
        e.rd  = w[11:7];
        e.imm = 32'd2 * 32'({w[31], w[19:12], w[20], w[30:21]}) - (w[31] ? 32'd2097152 : 32'd0);
      end
    endcase
    e.pc = pc;
    return e;
  endfunction

  task automatic compare_all();
    exp_t e;
    chk("count", 32'(bus.count_out), 32'(model.size()));
    for (int i = 0; i < int'(IW); i++) begin
      chk($sformatf("lane_valid[%0d]", i), 32'(bus.lane_valid_out[i]), 32'(i < model.size()));
      if (i < model.size()) begin
        e = model[i];
        chk($sformatf("itype[%0d]", i),   bus.iType_out[i],   e.itype);
        chk($sformatf("alu[%0d]", i),     bus.aluFunc_out[i], e.alu);
        chk($sformatf("br[%0d]", i),      bus.brFunc_out[i],  e.br);
        chk($sformatf("imm[%0d]", i),     bus.imm_out[i],     e.imm);
        chk($sformatf("pc[%0d]", i),      bus.pc_out[i],      e.pc);
        chk($sformatf("rs1[%0d]", i),     32'(bus.rs1_out[i]), 32'(e.rs1));
        chk($sformatf("rs2[%0d]", i),     32'(bus.rs2_out[i]), 32'(e.rs2));
        chk($sformatf("rd[%0d]", i),      32'(bus.rd_out[i]),  32'(e.rd));
        chk($sformatf("illegal[%0d]", i), 32'(bus.illegal_out[i]), 32'(e.ill));
      end
    end
  endtask

  // Drive one cycle, advance the model, then check after the edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input int deq, input logic fl, input logic r);
    int   sz, eff;
    logic acc;
    bus.fetch_valid_in = v;
    bus.instruction_in = inst;
    bus.pc_in          = pc;
    bus.deq_count_in   = 2'(deq);
    bus.flush_in       = fl;
    rst                = r;
    #1;
    chk("fetch_ready", 32'(bus.fetch_ready_out), 32'(model.size() < int'(DEPTH)));
    sz  = model.size();
    acc = v && (sz < int'(DEPTH));
    eff = (deq < sz) ? deq : sz;
    if (r || fl) model.delete();
    else begin
      repeat (eff) void'(model.pop_front());
      if (acc) model.push_back(ref_decode(inst, pc));
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  ops [11];
    int          s;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h00};
    w = $urandom;
    s = $urandom_range(0, 10);
    w[6:0] = (s == 10) ? 7'($urandom) : ops[s];
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      s = $urandom_range(0, 3);
      if (s == 0) w[31:25] = 7'h00;
      else if (s == 1) w[31:25] = 7'h20;
    end
    return w;
  endfunction

  vec_t tbl [14];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'hFFF00093, mk(IT_OPIMM, ALU_ADD, 0, 32'hFFFFFFFF, 0, 0, 1, 0)};
    tbl[1]  = '{32'h402081B3, mk(IT_OP, ALU_SUB, 0, 0, 1, 2, 3, 0)};
    tbl[2]  = '{32'hFE208EE3, mk(IT_BRANCH, 0, BR_EQ, 32'hFFFFFFFC, 1, 2, 0, 0)};
    tbl[3]  = '{32'h00000000, mk(0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[4]  = '{32'h123452B7, mk(IT_LUI, 0, 0, 32'h12345000, 0, 0, 5, 0)};
    tbl[5]  = '{32'h0080006F, mk(IT_JAL, 0, 0, 32'h00000008, 0, 0, 0, 0)};
    tbl[6]  = '{32'hFE20AE23, mk(IT_STORE, 0, 0, 32'hFFFFFFFC, 1, 2, 0, 0)};
    tbl[7]  = '{32'h4040D193, mk(IT_OPIMM, ALU_SRA, 0, 32'h00000404, 1, 0, 3, 0)};
    tbl[8]  = '{32'h40409193, mk(0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[9]  = '{32'hFE20AEE3, mk(0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[10] = '{32'h00000073, mk(0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[11] = '{32'h00812203, mk(IT_LOAD, 0, 0, 32'h00000008, 2, 0, 4, 0)};
    tbl[12] = '{32'hFFFFF097, mk(IT_AUIPC, 0, 0, 32'hFFFFF000, 0, 0, 1, 0)};
    tbl[13] = '{32'h000280E7, mk(IT_JALR, 0, 0, 0, 5, 0, 1, 0)};

    bus.fetch_valid_in = 1'b0;
    bus.instruction_in = '0;
    bus.pc_in          = '0;
    bus.deq_count_in   = '0;
    bus.flush_in       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(bus.count_out), 0);
    chk("reset_lane_valid", 32'(bus.lane_valid_out), 0);
    rst = 1'b0;
    #1;
    chk("reset_ready", 32'(bus.fetch_ready_out), 1);

    foreach (tbl[k]) begin
      step(1, tbl[k].inst, 32'h100 + 32'(k) * 4, 0, 0, 0);
      chk($sformatf("tbl%0d_itype", k), bus.iType_out[0], tbl[k].e.itype);
      chk($sformatf("tbl%0d_alu", k),   bus.aluFunc_out[0], tbl[k].e.alu);
      chk($sformatf("tbl%0d_br", k),    bus.brFunc_out[0], tbl[k].e.br);
      chk($sformatf("tbl%0d_imm", k),   bus.imm_out[0], tbl[k].e.imm);
      chk($sformatf("tbl%0d_pc", k),    bus.pc_out[0], 32'h100 + 32'(k) * 4);
      chk($sformatf("tbl%0d_regs", k),
          32'({bus.rs1_out[0], bus.rs2_out[0], bus.rd_out[0]}),
          32'({tbl[k].e.rs1, tbl[k].e.rs2, tbl[k].e.rd}));
      chk($sformatf("tbl%0d_illegal", k), 32'(bus.illegal_out[0]), 32'(tbl[k].e.ill));
      step(0, 0, 0, 1, 0, 0);
    end

    // Two-lane presentation, then consume both.
    step(1, 32'h402081B3, 32'h200, 0, 0, 0);
    step(1, 32'hFE208EE3, 32'h204, 0, 0, 0);
    chk("pair_lane0_alu", bus.aluFunc_out[0], ALU_SUB);
    chk("pair_lane1_itype", bus.iType_out[1], IT_BRANCH);
    chk("pair_lane1_imm", bus.imm_out[1], 32'hFFFFFFFC);
    step(0, 0, 0, 2, 0, 0);
    chk("pair_drained", 32'({bus.count_out, bus.lane_valid_out}), 0);

    // Fill past capacity: the 9th is held until a slot frees.
    for (int n = 0; n < 9; n++)
      step(1, 32'h00000013 | (32'(n) << 20) | (32'(n + 1) << 7), 32'h300 + 32'(n) * 4, 0, 0, 0);
    chk("full_count", 32'(bus.count_out), 8);
    chk("full_ready", 32'(bus.fetch_ready_out), 0);
    step(1, 32'h00800413, 32'h320, 1, 0, 0);
    chk("held_count", 32'(bus.count_out), 7);
    step(1, 32'h00800413, 32'h320, 0, 0, 0);
    chk("accepted_count", 32'(bus.count_out), 8);
    for (int n = 0; n < 20; n++)
      step(1, 32'h00000093 | (32'(n) << 20), 32'h400 + 32'(n) * 4, 1, 0, 0);
    repeat (4) step(0, 0, 0, 2, 0, 0);
    chk("laps_drained", 32'(bus.count_out), 0);

    // Flush overrides enqueue and dequeue.
    for (int n = 0; n < 5; n++) step(1, 32'h00100093, 32'h500 + 32'(n) * 4, 0, 0, 0);
    step(1, 32'h12345037, 32'h600, 2, 1, 0);
    chk("flush_count", 32'(bus.count_out), 0);
    chk("flush_lanes", 32'(bus.lane_valid_out), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("flush_not_stored", 32'(bus.count_out), 0);

    // Over-request dequeue.
    step(1, 32'h00100093, 32'h700, 0, 0, 0);
    step(0, 0, 0, 2, 0, 0);
    chk("underflow_count", 32'(bus.count_out), 0);
    step(0, 0, 0, 2, 0, 0);
    chk("empty_deq_count", 32'(bus.count_out), 0);

    // Reset with a full queue and a same-cycle enqueue.
    for (int n = 0; n < 8; n++) step(1, 32'h00200113, 32'h800 + 32'(n) * 4, 0, 0, 0);
    step(1, 32'h00300193, 32'h900, 0, 0, 1);
    chk("rst_lanes", 32'(bus.lane_valid_out), 0);
    chk("rst_ready", 32'(bus.fetch_ready_out), 1);
    chk("rst_count", 32'(bus.count_out), 0);

    for (int n = 0; n < 3000; n++)
      step(($urandom % 4) != 0, rand_inst(), $urandom & 32'hFFFFFFFC,
           $urandom_range(0, 2), ($urandom % 50) == 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
